pixel_stream_rx: RTL and testbench

PIXEL_STREAM_RX -- requirements
Module: pixel_stream_rx

---
 rtl/pixel_rx_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/pixel_stream_rx.sv | 145 ++++++++++++++
 tb/tb_pixel_stream_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_rx_pkg.sv
// Shared types and default geometry for the pixel stream receiver.
package pixel_rx_pkg;

    // Default geometry and buffering.
    localparam int PIX_DATA_W_DEF     = 8;
    localparam int PIX_COLS_DEF       = 2;
    localparam int PIX_ROWS_DEF       = 2;
    localparam int PIX_FIFO_DEPTH_DEF = 4;

    // Number of tag bits carried alongside each pixel word.
    localparam int PIX_TAG_W = 3;

    // Receiver frame state: waiting for a frame or collecting its pixels.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

    // Position tags attached to every buffered pixel.
    typedef struct packed {
        logic sof;  // row 0, col 0
        logic eol;  // last column of a row
        logic eof;  // last column of the last row
    } pix_tags_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
// Handshake: a word leaves on rd_valid & pop; rd_data is stable while rd_valid
// is high and no pop occurs. A push is accepted when not full, or when full
// and a pop happens the same cycle; otherwise it is dropped and 'drop' pulses.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    // Status, handshake qualification and next pointer/memory values.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        drop     = push && full && !do_pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        rd_valid = !empty;
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer and storage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/pixel_stream_rx.sv
// Pixel stream receiver: frames incoming pixels into rows/columns, tags
// sof/eol/eof, and buffers tagged words for a ready/valid consumer.
// Output handshake: a word transfers on out_valid & out_ready; while
// out_valid is high and out_ready low, out_data and tags hold stable.
module pixel_stream_rx
    import pixel_rx_pkg::*;
#(
    parameter int DATA_W     = PIX_DATA_W_DEF,
    parameter int COLS       = PIX_COLS_DEF,
    parameter int ROWS       = PIX_ROWS_DEF,
    parameter int FIFO_DEPTH = PIX_FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              frame_done,
    output logic              overflow,
    output logic              frame_err,
    output rx_state_e         dbg_state
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = DATA_W + PIX_TAG_W;

    rx_state_e   state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic        frame_done_q, frame_done_d;
    logic        overflow_q, overflow_d;
    logic        frame_err_q, frame_err_d;

    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic        accept;
    pix_tags_t   cur_tags;
    pix_tags_t   rd_tags;
    logic [FW-1:0] wr_word;
    logic [FW-1:0] rd_word;
    logic        fifo_pop;
    logic        fifo_drop;
    logic        fifo_valid;

    // Frame FSM, position counters, tagging and sticky status next-state.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_err_d  = frame_err_q;
        overflow_d   = overflow_q | fifo_drop;
        frame_done_d = 1'b0;

        // A frame_start restarts geometry at pixel 0 for any same-cycle pixel.
        cur_col = frame_start ? '0 : col_q;
        cur_row = frame_start ? '0 : row_q;
        accept  = pix_valid && (state_q == ST_RECV || frame_start);

        cur_tags.sof = (cur_row == '0) && (cur_col == '0);
        cur_tags.eol = (cur_col == CW'(COLS - 1));
        cur_tags.eof = cur_tags.eol && (cur_row == RW'(ROWS - 1));

        if (frame_start) begin
            if (state_q == ST_RECV) begin
                frame_err_d = 1'b1;
            end
            state_d = ST_RECV;
            col_d   = '0;
            row_d   = '0;
        end

        // Counters advance even when the FIFO drops the pixel.
        if (accept) begin
            if (cur_tags.eof) begin
                state_d      = ST_IDLE;
                col_d        = '0;
                row_d        = '0;
                frame_done_d = 1'b1;
            end else if (cur_tags.eol) begin
                col_d = '0;
                row_d = cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
            end
        end

        wr_word = {pix_data, cur_tags};
    end

    // State, counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
        end
    end

    sync_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .wr_data (wr_word),
        .pop     (fifo_pop),
        .rd_valid(fifo_valid),
        .rd_data (rd_word),
        .drop    (fifo_drop)
    );

    // Output unpacking and pop qualification.
    always_comb begin
        fifo_pop   = fifo_valid && out_ready;
        rd_tags    = rd_word[PIX_TAG_W-1:0];
        out_valid  = fifo_valid;
        out_data   = rd_word[FW-1:PIX_TAG_W];
        out_sof    = rd_tags.sof;
        out_eol    = rd_tags.eol;
        out_eof    = rd_tags.eof;
        frame_done = frame_done_q;
        overflow   = overflow_q;
        frame_err  = frame_err_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_pixel_stream_rx.sv
// Testbench for pixel_stream_rx: directed scenarios followed by random traffic,
// compared cycle by cycle against a position-and-queue reference model.
module tb_pixel_stream_rx;
    import pixel_rx_pkg::*;

    localparam int DATA_W = 8;
    localparam int COLS   = 2;
    localparam int ROWS   = 2;
    localparam int DEPTH  = 4;
    localparam int NPIX   = COLS * ROWS;
    localparam int W      = DATA_W + 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sof, out_eol, out_eof;
    logic              frame_done, overflow, frame_err;
    rx_state_e         dbg_state;

    pixel_stream_rx #(
        .DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .dbg_state  (dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Reference model: frame position index plus a bounded queue of words.
    logic [W-1:0] exp_q[$];
    bit           m_in_frame;
    int           m_pos;
    bit           m_done;
    bit           m_ovf;
    bit           m_err;

    int checks   = 0;
    int failures = 0;

    task automatic model_reset();
        exp_q.delete();
        m_in_frame = 0;
        m_pos      = 0;
        m_done     = 0;
        m_ovf      = 0;
        m_err      = 0;
    endtask

    task automatic model_step(input logic fs, input logic pv,
                              input logic [DATA_W-1:0] pd, input logic rdy);
        bit           pop;
        bit           acc;
        int           col;
        logic [W-1:0] word;
        pop    = (exp_q.size() > 0) && rdy;
        acc    = pv && (m_in_frame || fs);
        m_done = 0;
        if (fs) begin
            if (m_in_frame) m_err = 1;
            m_in_frame = 1;
            m_pos      = 0;
        end
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            col  = m_pos % COLS;
            word = {pd, (m_pos == 0), (col == COLS - 1), (m_pos == NPIX - 1)};
            if (exp_q.size() < DEPTH) exp_q.push_back(word);
            else m_ovf = 1;
            if (m_pos == NPIX - 1) begin
                m_done     = 1;
                m_in_frame = 0;
                m_pos      = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] exp_word;
        logic [W-1:0] obs_word;
        logic [2:0]   exp_stat;
        logic [2:0]   obs_stat;
        rx_state_e    exp_state;
        exp_word  = (exp_q.size() > 0) ? exp_q[0] : '0;
        obs_word  = {out_data, out_sof, out_eol, out_eof};
        exp_stat  = {m_done, m_ovf, m_err};
        obs_stat  = {frame_done, overflow, frame_err};
        exp_state = m_in_frame ? ST_RECV : ST_IDLE;

        checks++;
        assert (out_valid === (exp_q.size() > 0)) else begin
            failures++;
            $error("FAIL out_valid obs=%b exp=%b t=%0t", out_valid, (exp_q.size() > 0), $time);
        end
        checks++;
        assert (obs_word === exp_word) else begin
            failures++;
            $error("FAIL out_word{data,sof,eol,eof} obs=%h exp=%h t=%0t", obs_word, exp_word, $time);
        end
        checks++;
        assert (obs_stat === exp_stat) else begin
            failures++;
            $error("FAIL status{done,ovf,err} obs=%b exp=%b t=%0t", obs_stat, exp_stat, $time);
        end
        checks++;
        assert (dbg_state === exp_state) else begin
            failures++;
            $error("FAIL state obs=%0d exp=%0d t=%0t", dbg_state, exp_state, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, sample after the edge.
    task automatic cycle(input logic rst, input logic fs, input logic pv,
                         input logic [DATA_W-1:0] pd, input logic rdy);
        reset       = rst;
        frame_start = fs;
        pix_valid   = pv;
        pix_data    = pd;
        out_ready   = rdy;
        if (rst) model_reset();
        else model_step(fs, pv, pd, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, rdy);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        pix_data = '0; out_ready = 1'b0;
        model_reset();

        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);

        // Basic frame, consumer always ready.
        cycle(1'b0, 1'b1, 1'b1, 8'h10, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h20, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h30, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
        idle(2, 1'b1);

        // Backpressure: fill exactly to depth, hold, then release.
        cycle(1'b0, 1'b1, 1'b1, 8'hA0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hA3, 1'b0);
        idle(3, 1'b0);
        idle(5, 1'b1);

        // Overflow across two frames, then a clean frame keeps alignment.
        cycle(1'b0, 1'b1, 1'b1, 8'hB0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hB1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hB3, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'hC0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0);
        idle(5, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'hD0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'hD1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'hD2, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'hD3, 1'b1);
        idle(2, 1'b1);

        // Full FIFO with a simultaneous pop accepts the push.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'hE0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hE1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hE2, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hE3, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
        idle(6, 1'b1);

        // Restart mid-frame.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'h60, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h61, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'h62, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h63, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h64, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h65, 1'b1);
        idle(2, 1'b1);

        // Reset mid-frame, then stray pixels without frame_start are ignored.
        cycle(1'b0, 1'b1, 1'b1, 8'h70, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'h71, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'h72, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h73, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h74, 1'b1);

        // Random traffic with occasional restarts and resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 7),
                  DATA_W'($urandom),
                  ($urandom_range(0, 9) < 6));
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
